// File: rtl/proj_select_sequencer.sv
// Project-select sequencer for the user-area output mux: manual or scanning selection, with every
// change wrapped in a blanking guard window so the pads never show a mix of two projects.
module proj_select_sequencer #(
  parameter int unsigned NUM_PROJ = 11,
  parameter int unsigned GUARD    = 4,
  parameter int unsigned DWELL_W  = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_mode,
  input  logic [3:0]         cfg_sel,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               hold,
  output logic [3:0]         sel,
  output logic               blank,
  output logic               active,
  output logic               wrap_pulse
);

  localparam int unsigned GuardW   = $clog2(GUARD + 1);
  localparam logic [3:0]  LastProj = 4'(NUM_PROJ - 1);
  localparam logic [3:0]  NumProj  = 4'(NUM_PROJ);

  typedef enum logic [1:0] {
    StPre,
    StHold,
    StRun
  } state_e;

  state_e             state_q, state_d;
  logic [GuardW-1:0]  guard_q, guard_d;
  logic [3:0]         sel_q, sel_d;
  logic [3:0]         target_q, target_d;
  logic               mode_q, mode_d;
  logic               step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic               blank_q, ready_q;

  logic               accept;
  logic               expire;
  logic [3:0]         next_proj;

  assign accept    = cfg_valid & ready_q;
  assign expire    = mode_q & ~hold & (cnt_q == dwell_q - DWELL_W'(1));
  assign next_proj = (sel_q == LastProj) ? 4'd0 : sel_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    sel_d    = sel_q;
    target_d = target_q;
    mode_d   = mode_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;

    unique case (state_q)
      StPre: begin
        // Select switches only here, one cycle after blank has already risen.
        sel_d   = target_q;
        guard_d = GuardW'(GUARD - 1);
        wrap_d  = step_q & (sel_q == LastProj) & (target_q == 4'd0);
        state_d = StHold;
      end
      StHold: begin
        if (guard_q <= GuardW'(1)) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          guard_d = guard_q - GuardW'(1);
        end
      end
      StRun: begin
        if (accept) begin
          // A configuration write takes priority over a coinciding scan step.
          mode_d   = cfg_mode;
          dwell_d  = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
          target_d = (cfg_sel < NumProj) ? cfg_sel : 4'd0;
          step_d   = 1'b0;
          state_d  = StPre;
        end else if (expire) begin
          target_d = next_proj;
          step_d   = 1'b1;
          state_d  = StPre;
        end else if (mode_q && !hold) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: begin
        state_d = StHold;
        guard_d = GuardW'(GUARD);
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StHold;
      guard_q  <= GuardW'(GUARD);
      sel_q    <= 4'd0;
      target_q <= 4'd0;
      mode_q   <= 1'b0;
      step_q   <= 1'b0;
      dwell_q  <= DWELL_W'(1);
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      blank_q  <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      sel_q    <= sel_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      blank_q  <= (state_d != StRun);
      ready_q  <= (state_d == StRun);
    end
  end

  assign sel        = sel_q;
  assign blank      = blank_q;
  assign active     = ~blank_q;
  assign cfg_ready  = ready_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_proj_select_sequencer.sv
// Directed bench for proj_select_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_proj_select_sequencer;

  localparam int unsigned DwellW = 16;

  logic              clk;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_mode;
  logic [3:0]        cfg_sel;
  logic [DwellW-1:0] cfg_dwell;
  logic              hold;
  logic [3:0]        sel;
  logic              blank;
  logic              active;
  logic              wrap_pulse;

  int checks = 0;
  int errors = 0;

  proj_select_sequencer #(
    .NUM_PROJ(11),
    .GUARD   (4),
    .DWELL_W (DwellW)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_sel   (cfg_sel),
    .cfg_dwell (cfg_dwell),
    .hold      (hold),
    .sel       (sel),
    .blank     (blank),
    .active    (active),
    .wrap_pulse(wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one accepted write; returns at the sample point of the cycle after the accept edge.
  task automatic cfg_write(input logic mode, input logic [3:0] s, input int dwell);
    check("ready_before_write", int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_mode  = mode;
    cfg_sel   = s;
    cfg_dwell = DwellW'(dwell);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // From the PRE sample: 1 PRE cycle, 3 HOLD cycles, then lands on the first RUN cycle.
  task automatic guard_check(input int old_sel, input int new_sel, input int exp_wrap);
    check("pre_blank", int'(blank), 1);
    check("pre_sel", int'(sel), old_sel);
    check("pre_ready", int'(cfg_ready), 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("hold_blank", int'(blank), 1);
      check("hold_active", int'(active), 0);
      check("hold_sel", int'(sel), new_sel);
      check("hold_wrap", int'(wrap_pulse), (k == 0) ? exp_wrap : 0);
      @(negedge clk);
    end
    check("run_blank", int'(blank), 0);
    check("run_active", int'(active), 1);
    check("run_ready", int'(cfg_ready), 1);
    check("run_sel", int'(sel), new_sel);
  endtask

  // From the first RUN cycle: run_cycles RUN cycles (the first hold_cycles with hold=1), then guard.
  task automatic scan_step(input int cur, input int nxt, input int run_cycles,
                           input int hold_cycles, input int exp_wrap);
    for (int i = 0; i < run_cycles; i++) begin
      check("scan_run_blank", int'(blank), 0);
      check("scan_run_sel", int'(sel), cur);
      check("scan_run_wrap", int'(wrap_pulse), 0);
      hold = (i < hold_cycles);
      @(negedge clk);
    end
    hold = 1'b0;
    guard_check(cur, nxt, exp_wrap);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_mode  = 1'b0;
    cfg_sel   = 4'd0;
    cfg_dwell = '0;
    hold      = 1'b0;

    // Reset and release
    repeat (3) @(negedge clk);
    check("rst_sel", int'(sel), 0);
    check("rst_blank", int'(blank), 1);
    check("rst_active", int'(active), 0);
    check("rst_ready", int'(cfg_ready), 0);
    check("rst_wrap", int'(wrap_pulse), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rel_blank", int'(blank), 1);
      check("rel_sel", int'(sel), 0);
      check("rel_ready", int'(cfg_ready), 0);
      @(negedge clk);
    end
    check("rel_run_blank", int'(blank), 0);
    check("rel_run_ready", int'(cfg_ready), 1);
    check("rel_run_active", int'(active), 1);

    // Manual select, then held for 100 cycles
    cfg_write(1'b0, 4'd5, 0);
    guard_check(0, 5, 0);
    for (int i = 0; i < 100; i++) begin
      check("man_stable_sel", int'(sel), 5);
      check("man_stable_blank", int'(blank), 0);
      @(negedge clk);
    end

    // Out-of-range and top-of-range selects
    cfg_write(1'b0, 4'd12, 0);
    guard_check(5, 0, 0);
    cfg_write(1'b0, 4'd10, 0);
    guard_check(0, 10, 0);

    // Scan from 9 with dwell 3: 9 -> 10 -> 0 with a wrap pulse on entry to 0
    cfg_write(1'b1, 4'd9, 3);
    guard_check(10, 9, 0);
    scan_step(9, 10, 3, 0, 0);
    scan_step(10, 0, 3, 0, 1);

    // Dwell 0 behaves as dwell 1
    cfg_write(1'b1, 4'd2, 0);
    guard_check(0, 2, 0);
    scan_step(2, 3, 1, 0, 0);

    // With dwell 1 every RUN cycle expires: the write must win, no step to 4
    cfg_write(1'b1, 4'd7, 3);
    guard_check(3, 7, 0);

    // hold for 5 cycles stretches a dwell of 3 to 8 RUN cycles
    scan_step(7, 8, 8, 5, 0);

    // cfg_valid raised during HOLD stays pending until the first RUN cycle
    cfg_write(1'b0, 4'd3, 0);
    check("mid_pre_sel", int'(sel), 8);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_mode  = 1'b0;
    cfg_sel   = 4'd6;
    for (int k = 0; k < 3; k++) begin
      check("mid_hold_ready", int'(cfg_ready), 0);
      check("mid_hold_sel", int'(sel), 3);
      @(negedge clk);
    end
    check("mid_run_ready", int'(cfg_ready), 1);
    check("mid_run_sel", int'(sel), 3);
    @(negedge clk);
    cfg_valid = 1'b0;
    guard_check(3, 6, 0);

    // Reset mid-HOLD restarts the guard with sel=0
    cfg_write(1'b0, 4'd9, 0);
    @(negedge clk);
    check("midrst_hold_sel", int'(sel), 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("midrst_blank", int'(blank), 1);
      check("midrst_sel", int'(sel), 0);
      check("midrst_ready", int'(cfg_ready), 0);
      @(negedge clk);
    end
    check("midrst_run_blank", int'(blank), 0);
    check("midrst_run_ready", int'(cfg_ready), 1);
    check("midrst_run_sel", int'(sel), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proj_select_sequencer.md
# proj_select_sequencer

Sequencer that drives the 4-bit project-select input of the 16-bit output mux in the multi-project user area. In manual mode it applies a single configured selection. In scan mode it steps through projects 0..NUM_PROJ-1 on a programmable dwell period. Every selection change is wrapped in a guard window that asserts `blank`, which the top level uses to force `io_out` to 0 and `io_oeb` high, so pads never show a mid-switch mix of two projects.

## Interface
- NUM_PROJ, 11, number of valid mux inputs; legal select values are 0..NUM_PROJ-1
- GUARD, 4, blanking cycles per selection change; must be ≥2
- DWELL_W, 16, width of the dwell counter and of `cfg_dwell`

- wb_clk_i  in  1  clock; single clock domain
- wb_rst_i  in  1  reset, synchronous, active-high
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration can be accepted; transfer occurs on a cycle with cfg_valid & cfg_ready
- cfg_mode  in  1  0 = manual, 1 = scan
- cfg_sel  in  4  requested project (manual mode) or start project (scan mode)
- cfg_dwell  in  DWELL_W  scan dwell in cycles; 0 is treated as 1
- hold  in  1  freezes the scan dwell counter
- sel  out  4  mux select
- blank  out  1  guard window active
- active  out  1  selection is stable and outputs are valid (equal to !blank)
- wrap_pulse  out  1  one-cycle pulse when scan wraps from NUM_PROJ-1 to 0

## Operation
- States:
  - PRE: blank=1, old `sel` held, 1 cycle.
  - HOLD: blank=1, new `sel` driven, GUARD-1 cycles.
  - RUN: blank=0, cfg_ready=1.
- Reset, while wb_rst_i is sampled high:
  - sel=0, mode=manual, dwell_reg=1.
  - State=HOLD with guard count GUARD.
  - blank=1, active=0, cfg_ready=0, wrap_pulse=0.
- cfg_ready is 1 only in RUN. cfg_valid asserted in PRE or HOLD stays pending, with no effect, until RUN.
- On accept in RUN:
  - Latch mode. Latch dwell_reg = max(cfg_dwell, 1).
  - Latch target = cfg_sel if cfg_sel < NUM_PROJ, otherwise 0.
  - Go to PRE.
  - The guard sequence always runs, even when target equals the current sel.
- PRE→HOLD: sel ← target.
- HOLD→RUN: after GUARD-1 HOLD cycles. The dwell counter is cleared on RUN entry.
- Scan mode, RUN state:
  - The dwell counter increments on each cycle with hold=0. With hold=1 it keeps its value.
  - When count == dwell_reg-1 and hold=0: target = (sel==NUM_PROJ-1) ? 0 : sel+1, then go to PRE.
- Manual mode: the dwell counter is ignored and sel is held indefinitely.
- Simultaneous accept and dwell expiry: the accept wins. The scan step is discarded.
- wrap_pulse is 1 for exactly the cycle after the PRE→HOLD edge on which sel changes from NUM_PROJ-1 to 0 in scan mode. A manual write of 0 never pulses.
- Reset asserted in any state, including mid-guard, returns to the reset values on the next edge.

## Timing
- Accept on edge N:
  - blank=1 from N.
  - sel=new from N+1.
  - blank=0, active=1 and cfg_ready=1 from N+GUARD.
  - Total blank time: GUARD cycles.
- After reset release, blank stays 1 for GUARD cycles with sel=0. cfg_ready rises after that.
- Scan period per project: dwell_reg RUN cycles plus GUARD blank cycles, plus any cycles with hold=1.
- sel never changes while blank=0. sel never changes in the same cycle that blank rises.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset and release: hold wb_rst_i high 3 cycles, then release → sel=0 and blank=1 for 4 cycles, then blank=0 and cfg_ready=1.
- Manual select: cfg_sel=5, mode=0, accepted at edge N → blank=1 at N, sel=5 at N+1, blank=0 at N+4. sel stays 5 for 100 cycles.
- Out-of-range select: cfg_sel=12 → sel=0 after the guard. cfg_sel=10 → sel=10.
- Scan wrap: mode=1, cfg_sel=9, dwell=3 → sel=9 for 3 RUN cycles, 4 blank cycles, then 10, then 0. wrap_pulse is high for exactly one cycle, aligned with sel becoming 0.
- Hold and dwell 0:
  - Scan with dwell=0 behaves as dwell=1.
  - hold=1 for 5 cycles during a dwell of 3 stretches that RUN period to 8 cycles.
  - Accept coinciding with dwell expiry → the configured sel is applied and no increment occurs.
- Mid-operation: cfg_valid during HOLD → cfg_ready=0, accepted on the first RUN cycle. Reset asserted mid-HOLD → sel=0 and blank=1 on the next edge, with the guard restarted.
